phase_tracker: RTL and testbench

Receive-side counterpart of the phase accumulator. Consumes the 8-bit phase stream (256 points per 2π) and recovers the generator's settings: step (frequency), initial phase, and samples per period. Sits on the loop-back/monitor path of the function generator; used for self-check and on-board frequency readout.

---
 rtl/phase_tracker.sv | 139 +++++++++++++
 tb/tb_phase_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_tracker.sv
// phase_tracker: recovers step, init phase and period length from an 8-bit phase stream.
// Latency: one cycle; a sample accepted at an edge is visible on all outputs right after it.
// Backpressure: none; one sample per cycle, in_valid=0 holds all state and drops the pulses.
// Ports: clk, en (async active-low clear), in_valid/phase_in (sample in),
//        step_out/locked (recovered step), init_out/wrap (phase at last wrap, wrap pulse),
//        period_len/period_valid (samples in last full period), slip (lock-lost pulse).
module phase_tracker #(
    parameter int LOCK_COUNT = 4,
    parameter int PCW        = 9
) (
    input  logic           clk,
    input  logic           en,
    input  logic           in_valid,
    input  logic [7:0]     phase_in,
    output logic [7:0]     step_out,
    output logic [7:0]     init_out,
    output logic [PCW-1:0] period_len,
    output logic           period_valid,
    output logic           locked,
    output logic           wrap,
    output logic           slip
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {EMPTY, ACQUIRE, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [7:0]     prev, prev_nxt;
    logic [7:0]     cand, cand_nxt;
    logic [MW-1:0]  match_cnt, match_cnt_nxt;
    logic [PCW-1:0] period_cnt, period_cnt_nxt;
    logic           seen_wrap, seen_wrap_nxt;
    logic [7:0]     step_nxt, init_nxt;
    logic [PCW-1:0] period_len_nxt;
    logic           period_valid_nxt, locked_nxt, wrap_nxt, slip_nxt;

    logic           is_wrap;
    logic [7:0]     diff;
    logic [MW-1:0]  match_new;
    logic [PCW-1:0] period_inc;

    // Non-wrap samples satisfy phase_in >= prev, so the difference never borrows.
    assign is_wrap    = phase_in < prev;
    assign diff       = phase_in - prev;
    assign match_new  = (diff != cand)            ? MW'(1)    :
                        (match_cnt == MATCH_LOCK) ? match_cnt : match_cnt + MW'(1);
    assign period_inc = (period_cnt == '1) ? period_cnt : period_cnt + PCW'(1);

    always_comb begin
        state_nxt        = state;
        prev_nxt         = prev;
        cand_nxt         = cand;
        match_cnt_nxt    = match_cnt;
        period_cnt_nxt   = period_cnt;
        seen_wrap_nxt    = seen_wrap;
        step_nxt         = step_out;
        init_nxt         = init_out;
        period_len_nxt   = period_len;
        period_valid_nxt = period_valid;
        locked_nxt       = locked;
        wrap_nxt         = 1'b0;
        slip_nxt         = 1'b0;

        if (in_valid) begin
            prev_nxt = phase_in;
            if (state == EMPTY) begin
                // First sample only seeds prev; there is nothing to diff against.
                period_cnt_nxt = PCW'(1);
                state_nxt      = ACQUIRE;
            end else if (is_wrap) begin
                // The wrap difference is not a step, so lock tracking is left alone.
                wrap_nxt       = 1'b1;
                init_nxt       = phase_in;
                period_cnt_nxt = PCW'(1);
                seen_wrap_nxt  = 1'b1;
                // The period before the first wrap may be partial, so it is not reported.
                if (seen_wrap) begin
                    period_len_nxt   = period_cnt;
                    period_valid_nxt = 1'b1;
                end
            end else begin
                period_cnt_nxt = period_inc;
                if (state == LOCKED) begin
                    if (diff != step_out) begin
                        // step_out keeps its stale value; locked tells the user not to trust it.
                        slip_nxt      = 1'b1;
                        locked_nxt    = 1'b0;
                        cand_nxt      = diff;
                        match_cnt_nxt = MW'(1);
                        state_nxt     = ACQUIRE;
                    end
                end else begin
                    cand_nxt      = diff;
                    match_cnt_nxt = match_new;
                    if (match_new == MATCH_LOCK) begin
                        step_nxt   = diff;
                        locked_nxt = 1'b1;
                        state_nxt  = LOCKED;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state        <= EMPTY;
            prev         <= '0;
            cand         <= '0;
            match_cnt    <= '0;
            period_cnt   <= '0;
            seen_wrap    <= 1'b0;
            step_out     <= '0;
            init_out     <= '0;
            period_len   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            wrap         <= 1'b0;
            slip         <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev         <= prev_nxt;
            cand         <= cand_nxt;
            match_cnt    <= match_cnt_nxt;
            period_cnt   <= period_cnt_nxt;
            seen_wrap    <= seen_wrap_nxt;
            step_out     <= step_nxt;
            init_out     <= init_nxt;
            period_len   <= period_len_nxt;
            period_valid <= period_valid_nxt;
            locked       <= locked_nxt;
            wrap         <= wrap_nxt;
            slip         <= slip_nxt;
        end
    end

endmodule

// File: tb/tb_phase_tracker.sv
// tb_phase_tracker: randomized and directed stimulus against a run-length reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: none; in_valid gaps are inserted by the stimulus itself.
module tb_phase_tracker;

    localparam int LC  = 4;
    localparam int PCW = 9;
    localparam int PMAX = (1 << PCW) - 1;

    logic           clk;
    logic           en;
    logic           in_valid;
    logic [7:0]     phase_in;
    logic [7:0]     step_out;
    logic [7:0]     init_out;
    logic [PCW-1:0] period_len;
    logic           period_valid;
    logic           locked;
    logic           wrap;
    logic           slip;

    phase_tracker #(.LOCK_COUNT(LC), .PCW(PCW)) dut (
        .clk          (clk),
        .en           (en),
        .in_valid     (in_valid),
        .phase_in     (phase_in),
        .step_out     (step_out),
        .init_out     (init_out),
        .period_len   (period_len),
        .period_valid (period_valid),
        .locked       (locked),
        .wrap         (wrap),
        .slip         (slip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: lock is "the current run of equal non-wrap diffs is at
    // least LC long"; period is a count of samples since the last wrap.
    int m_have, m_prev, m_rval, m_rlen, m_locked, m_step;
    int m_init, m_seen, m_pcnt, m_plen, m_pvld, m_wrap, m_slip;

    task automatic model_reset();
        m_have = 0; m_prev = 0; m_rval = 0; m_rlen = 0; m_locked = 0; m_step = 0;
        m_init = 0; m_seen = 0; m_pcnt = 0; m_plen = 0; m_pvld = 0; m_wrap = 0; m_slip = 0;
    endtask

    task automatic model_sample(input int x);
        int d;
        m_wrap = 0;
        m_slip = 0;
        if (m_have == 0) begin
            m_have = 1;
            m_pcnt = 1;
        end else if (x < m_prev) begin
            m_wrap = 1;
            m_init = x;
            if (m_seen != 0) begin
                m_plen = m_pcnt;
                m_pvld = 1;
            end
            m_seen = 1;
            m_pcnt = 1;
        end else begin
            d = x - m_prev;
            m_pcnt = (m_pcnt + 1 > PMAX) ? PMAX : m_pcnt + 1;
            if (m_rlen > 0 && d == m_rval) begin
                m_rlen++;
            end else begin
                if (m_locked != 0) m_slip = 1;
                m_rval = d;
                m_rlen = 1;
            end
            m_locked = (m_rlen >= LC && m_slip == 0) ? 1 : 0;
            if (m_locked != 0) m_step = m_rval;
        end
        m_prev = x;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " step_out"},     int'(step_out),     m_step);
        chk({ctx, " init_out"},     int'(init_out),     m_init);
        chk({ctx, " period_len"},   int'(period_len),   m_plen);
        chk({ctx, " period_valid"}, int'(period_valid), m_pvld);
        chk({ctx, " locked"},       int'(locked),       m_locked);
        chk({ctx, " wrap"},         int'(wrap),         m_wrap);
        chk({ctx, " slip"},         int'(slip),         m_slip);
    endtask

    task automatic check_zero(input string ctx);
        chk({ctx, " step_out"},     int'(step_out),     0);
        chk({ctx, " init_out"},     int'(init_out),     0);
        chk({ctx, " period_len"},   int'(period_len),   0);
        chk({ctx, " period_valid"}, int'(period_valid), 0);
        chk({ctx, " locked"},       int'(locked),       0);
        chk({ctx, " wrap"},         int'(wrap),         0);
        chk({ctx, " slip"},         int'(slip),         0);
    endtask

    task automatic send(input string ctx, input int x);
        @(negedge clk);
        in_valid = 1'b1;
        phase_in = 8'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_sample(x);
        check_all(ctx);
    endtask

    task automatic gap(input string ctx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            phase_in = 8'($urandom);
            @(posedge clk);
            #1;
            m_wrap = 0;
            m_slip = 0;
            check_all(ctx);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        en = 1'b0;
        #2;
        check_zero("rst");
        @(negedge clk);
        en = 1'b1;
        model_reset();
    endtask

    initial begin
        int st, ini, len;
        en = 1'b0;
        in_valid = 1'b0;
        phase_in = '0;
        model_reset();

        // Reset held with in_valid toggling: everything stays cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            phase_in = 8'($urandom);
            @(posedge clk);
            #1;
            check_zero("reset_hold");
        end
        @(negedge clk);
        in_valid = 1'b0;
        en = 1'b1;
        gap("post_reset", 3);
        check_zero("post_reset_zero");

        // Lock on step 3 after exactly LC+1 samples.
        do_reset();
        send("lock", 0);
        send("lock", 3);
        send("lock", 6);
        send("lock", 9);
        chk("lock_4th locked", int'(locked), 0);
        send("lock", 12);
        chk("lock_5th locked", int'(locked), 1);
        chk("lock_5th step", int'(step_out), 3);

        // Wrap and period length.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send("wrapper", (10 + 64 * k) % 256);
            if (k == 4) begin
                chk("wrap_s5 wrap", int'(wrap), 1);
                chk("wrap_s5 pvalid", int'(period_valid), 0);
            end
            if (k == 7) begin
                chk("wrap_s8 locked", int'(locked), 1);
                chk("wrap_s8 step", int'(step_out), 64);
            end
        end
        chk("wrap_s9 wrap", int'(wrap), 1);
        chk("wrap_s9 init", int'(init_out), 10);
        chk("wrap_s9 plen", int'(period_len), 4);
        chk("wrap_s9 pvalid", int'(period_valid), 1);

        // Slip and relock at a new step.
        do_reset();
        for (int k = 0; k < 5; k++) send("slip_lock", 5 * k);
        chk("slip_pre locked", int'(locked), 1);
        send("slip", 27);
        chk("slip_pulse", int'(slip), 1);
        chk("slip_unlock", int'(locked), 0);
        send("slip", 34);
        send("slip", 41);
        chk("slip_3rd locked", int'(locked), 0);
        send("slip", 48);
        chk("relock locked", int'(locked), 1);
        chk("relock step", int'(step_out), 7);

        // Step-3 stream with random idle gaps.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            send("gaps", 3 * k);
            gap("gaps_idle", $urandom_range(0, 3));
        end
        chk("gaps locked", int'(locked), 1);
        chk("gaps step", int'(step_out), 3);
        chk("gaps init", int'(init_out), 0);

        // Asynchronous reset mid-run.
        do_reset();
        send("mid", 0);
        send("mid", 3);
        send("mid", 6);
        @(negedge clk);
        #2;
        en = 1'b0;
        #1;
        check_zero("mid_async");
        @(negedge clk);
        en = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) send("mid_resume", 50 + 3 * k);
        chk("mid locked", int'(locked), 1);
        chk("mid step", int'(step_out), 3);
        chk("mid init", int'(init_out), 0);
        chk("mid wrap", int'(wrap), 0);

        // Random generator settings with occasional corrupted samples and gaps.
        for (int s = 0; s < 10; s++) begin
            if (s % 2 == 0) do_reset();
            ini = $urandom_range(0, 255);
            st  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            len = $urandom_range(8, 40);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 11) == 0) send("rand_glitch", $urandom_range(0, 255));
                else send("rand", (ini + k * st) % 256);
                gap("rand_idle", $urandom_range(0, 2));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
